// File: rtl/snoopy_bus_arbiter_if.sv
// snoopy_bus_arbiter_if: request/grant bundle between cache controllers and the bus arbiter.
interface snoopy_bus_arbiter_if #(parameter int DEVICE_NUMBER = 4);
    localparam int DEVICE_WIDTH = $clog2(DEVICE_NUMBER);
    logic [DEVICE_NUMBER-1:0] requests;
    logic [DEVICE_NUMBER-1:0] grants;
    logic [DEVICE_WIDTH-1:0]  ownerId;
    logic                     busy;
    modport master (input requests, output grants, ownerId, busy);
    modport slave  (output requests, input grants, ownerId, busy);
endinterface

// File: rtl/snoopy_bus_arbiter.sv
// snoopy_bus_arbiter: round-robin, non-preemptive owner selection for the shared snoopy bus.
// ARBITER_TURNAROUND_EN inserts one dead cycle (no grant) on every ownership change.
module snoopy_bus_arbiter #(
    parameter int DEVICE_NUMBER = 4,
    localparam int DEVICE_WIDTH = $clog2(DEVICE_NUMBER)
) (
    input logic clock,
    input logic reset,
    snoopy_bus_arbiter_if.master bus
);
`ifdef ARBITER_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE, GRANTED, TURNAROUND} state_t;
`else
    typedef enum logic {IDLE, GRANTED} state_t;
`endif
    state_t state, state_n;
    logic [DEVICE_WIDTH-1:0]  ptr, ptr_n, release_ptr, search_ptr, pick, owner_n;
    logic [DEVICE_NUMBER-1:0] grants_n;
    logic                     busy_n, found, rel;

    function automatic logic [DEVICE_WIDTH:0] wrap(input logic [DEVICE_WIDTH:0] v);
        return v >= (DEVICE_WIDTH+1)'(DEVICE_NUMBER) ? v - (DEVICE_WIDTH+1)'(DEVICE_NUMBER) : v;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            bus.grants  <= '0;
            bus.ownerId <= '0;
            bus.busy    <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            bus.grants  <= grants_n;
            bus.ownerId <= owner_n;
            bus.busy    <= busy_n;
        end
    end

    // On release the search starts just past the old owner, so it ranks last.
    always_comb begin
        rel         = state == GRANTED && !bus.requests[bus.ownerId];
        release_ptr = DEVICE_WIDTH'(wrap({1'b0, bus.ownerId} + 1'b1));
        search_ptr  = state == GRANTED ? release_ptr : ptr;
        found       = 1'b0;
        pick        = '0;
        for (int k = DEVICE_NUMBER - 1; k >= 0; k--)
            if (bus.requests[wrap({1'b0, search_ptr} + (DEVICE_WIDTH+1)'(k))]) begin
                found = 1'b1;
                pick  = DEVICE_WIDTH'(wrap({1'b0, search_ptr} + (DEVICE_WIDTH+1)'(k)));
            end
    end

    always_comb begin
        state_n = state;
        if (state != GRANTED)
            state_n = found ? GRANTED : IDLE;
        else if (rel)
`ifdef ARBITER_TURNAROUND_EN
            state_n = TURNAROUND;
`else
            state_n = found ? GRANTED : IDLE;
`endif
    end

    always_comb begin
        grants_n = bus.grants;
        owner_n  = bus.ownerId;
        busy_n   = bus.busy;
        ptr_n    = ptr;
        if (state != GRANTED) begin
            grants_n = found ? DEVICE_NUMBER'(1) << pick : '0;
            owner_n  = found ? pick : bus.ownerId;
            busy_n   = found;
        end else if (rel) begin
            ptr_n = release_ptr;
`ifdef ARBITER_TURNAROUND_EN
            grants_n = '0;
            busy_n   = 1'b0;
`else
            grants_n = found ? DEVICE_NUMBER'(1) << pick : '0;
            owner_n  = found ? pick : bus.ownerId;
            busy_n   = found;
`endif
        end
    end
endmodule
